// File: rtl/zstd_header_writer_if.sv
// Output stream of the Zstandard frame header writer.
//   out_data  [15:0] : [7:0] earlier stream byte, [15:8] next byte
//   out_valid        : out_data valid
//   out_ready        : sink accepts when out_valid && out_ready
//   out_last         : final word of the header
//   out_bytes [1:0]  : valid bytes in word (2, or 1 on an odd-length final word)
interface zstd_header_writer_if;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [1:0]  out_bytes;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    output out_bytes,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    input  out_bytes,
    output out_ready
  );
endinterface

// File: rtl/zstd_header_writer.sv
// Serialises a Zstandard frame header (magic, FHD, optional Window_Descriptor,
// Dictionary_ID, Frame_Content_Size) into 16-bit little-endian words.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start                 : one-cycle request, header fields sampled this cycle
//   single_segment        : FHD bit 5, suppresses the Window_Descriptor
//   checksum_flag         : FHD bit 2
//   did_flag [1:0]        : Dictionary_ID size code (0/1/2/4 bytes)
//   fcs_flag [1:0]        : Frame_Content_Size size code
//   window_descriptor     : emitted only when single_segment = 0
//   dictionary_id [31:0]  : low did-size bytes emitted
//   frame_content_size    : low fcs-size bytes emitted (2-byte form is value-256)
//   out_if                : output word stream (master side)
//   header_len [4:0]      : total header bytes, valid from LOAD until next start
//   busy, done, cfg_error : status; done and cfg_error are one-cycle pulses
module zstd_header_writer #(
  parameter logic [31:0] MAGIC     = 32'hFD2FB528,
  parameter bit          CHECK_FCS = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        single_segment,
  input  logic                        checksum_flag,
  input  logic [1:0]                  did_flag,
  input  logic [1:0]                  fcs_flag,
  input  logic [7:0]                  window_descriptor,
  input  logic [31:0]                 dictionary_id,
  input  logic [63:0]                 frame_content_size,
  zstd_header_writer_if.master        out_if,
  output logic [4:0]                  header_len,
  output logic                        busy,
  output logic                        done,
  output logic                        cfg_error
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT, S_DONE} state_t;

  function automatic logic [2:0] did_size(input logic [1:0] flag);
    case (flag)
      2'd0:    did_size = 3'd0;
      2'd1:    did_size = 3'd1;
      2'd2:    did_size = 3'd2;
      default: did_size = 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] fcs_size(input logic [1:0] flag, input logic ss);
    case (flag)
      2'd0:    fcs_size = ss ? 4'd1 : 4'd0;
      2'd1:    fcs_size = 4'd2;
      2'd2:    fcs_size = 4'd4;
      default: fcs_size = 4'd8;
    endcase
  endfunction

  state_t       state_q;
  logic         ss_q, chk_q;
  logic [1:0]   did_flag_q, fcs_flag_q;
  logic [7:0]   wd_q;
  logic [31:0]  did_q;
  logic [63:0]  fcs_q;
  logic [143:0] buf_q;
  logic [3:0]   word_q, nwords_q;
  logic [4:0]   len_q;
  logic [15:0]  out_data_q;
  logic         out_valid_q, out_last_q;
  logic [1:0]   out_bytes_q;
  logic         busy_q, done_q, cfg_err_q;

  logic [143:0] buf_d;
  logic [103:0] tail;
  logic [63:0]  fcs_bytes;
  logic [31:0]  did_bytes;
  logic [7:0]   fhd;
  logic [2:0]   did_sz;
  logic [4:0]   len_in;
  logic         fcs_bad;

  // Request-time checks on the live inputs.
  always_comb begin
    len_in  = 5'd5 + {4'd0, ~single_segment} + {2'd0, did_size(did_flag)}
              + {1'b0, fcs_size(fcs_flag, single_segment)};
    fcs_bad = CHECK_FCS && (fcs_flag == 2'd1) &&
              ((frame_content_size < 64'd256) || (frame_content_size > 64'd65791));
  end

  // Variable-length fields are stacked from the far end (FCS) toward the
  // FHD by shifting, so each field lands directly after its predecessor.
  always_comb begin
    did_sz = did_size(did_flag_q);
    fhd    = {fcs_flag_q, ss_q, 2'b00, chk_q, did_flag_q};
    case (fcs_flag_q)
      2'd0:    fcs_bytes = ss_q ? {56'd0, fcs_q[7:0]} : '0;
      2'd1:    fcs_bytes = {48'd0, fcs_q[15:0] - 16'h0100};
      2'd2:    fcs_bytes = {32'd0, fcs_q[31:0]};
      default: fcs_bytes = fcs_q;
    endcase
    case (did_flag_q)
      2'd0:    did_bytes = '0;
      2'd1:    did_bytes = {24'd0, did_q[7:0]};
      2'd2:    did_bytes = {16'd0, did_q[15:0]};
      default: did_bytes = did_q;
    endcase
    tail = 104'(fcs_bytes);
    tail = (tail << {did_sz, 3'b000}) | 104'(did_bytes);
    if (!ss_q) begin
      tail = {tail[95:0], wd_q};
    end
    buf_d = {tail, fhd, MAGIC};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ss_q        <= 1'b0;
      chk_q       <= 1'b0;
      did_flag_q  <= '0;
      fcs_flag_q  <= '0;
      wd_q        <= '0;
      did_q       <= '0;
      fcs_q       <= '0;
      buf_q       <= '0;
      word_q      <= '0;
      nwords_q    <= '0;
      len_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_bytes_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            ss_q       <= single_segment;
            chk_q      <= checksum_flag;
            did_flag_q <= did_flag;
            fcs_flag_q <= fcs_flag;
            wd_q       <= window_descriptor;
            did_q      <= dictionary_id;
            fcs_q      <= frame_content_size;
            if (fcs_bad) begin
              cfg_err_q <= 1'b1;
            end else begin
              len_q   <= len_in;
              busy_q  <= 1'b1;
              state_q <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          buf_q       <= buf_d;
          word_q      <= '0;
          nwords_q    <= len_q[4:1] + {3'd0, len_q[0]};
          out_data_q  <= buf_d[15:0];
          out_valid_q <= 1'b1;
          out_last_q  <= 1'b0;
          out_bytes_q <= 2'd2;
          state_q     <= S_EMIT;
        end
        S_EMIT: begin
          if (out_valid_q && out_if.out_ready) begin
            if (out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_bytes_q <= '0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              // The buffer shifts down one word per accept so the next word
              // is always at [31:16]; zero fill pads an odd final byte.
              buf_q       <= {16'd0, buf_q[143:16]};
              out_data_q  <= buf_q[31:16];
              word_q      <= word_q + 4'd1;
              out_last_q  <= (word_q + 4'd2 == nwords_q);
              out_bytes_q <= ((word_q + 4'd2 == nwords_q) && len_q[0]) ? 2'd1 : 2'd2;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_last  = out_last_q;
  assign out_if.out_bytes = out_bytes_q;
  assign header_len       = len_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign cfg_error        = cfg_err_q;

endmodule

// File: tb/tb_zstd_header_writer.sv
// Directed bench for zstd_header_writer: header word sequences, back-pressure,
// start-while-busy, FCS range errors and mid-header reset.
module tb_zstd_header_writer;
  logic        clk = 1'b0;
  logic        reset, start, ss, ck;
  logic [1:0]  didf, fcsf;
  logic [7:0]  wd;
  logic [31:0] did;
  logic [63:0] fcs;
  logic [4:0]  header_len;
  logic        busy, done, cfg_error;

  int checks = 0;
  int errors = 0;
  logic [15:0] ew [9];

  always #5 clk = ~clk;

  zstd_header_writer_if hs();

  zstd_header_writer #(
    .MAGIC     (32'hFD2FB528),
    .CHECK_FCS (1'b1)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .single_segment     (ss),
    .checksum_flag      (ck),
    .did_flag           (didf),
    .fcs_flag           (fcsf),
    .window_descriptor  (wd),
    .dictionary_id      (did),
    .frame_content_size (fcs),
    .out_if             (hs.master),
    .header_len         (header_len),
    .busy               (busy),
    .done               (done),
    .cfg_error          (cfg_error)
  );

  task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input logic s, input logic c, input logic [1:0] df,
                            input logic [1:0] ff, input logic [7:0] w,
                            input logic [31:0] d, input logic [63:0] f);
    ss = s; ck = c; didf = df; fcsf = ff; wd = w; did = d; fcs = f;
  endtask

  // Issues start, then checks LOAD, every word against ew[], and the done pulse.
  // stall_k >= 0 holds out_ready low for 3 cycles at that word and pulses an
  // invalid start meanwhile, which must be ignored.
  task automatic run_header(input string tag, input int nw, input logic [4:0] len,
                            input logic [1:0] last_bytes, input int stall_k);
    logic [1:0]  sv_fcsf;
    logic [63:0] sv_fcs;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    expect_eq({tag, " load busy"}, 64'(busy), 64'd1);
    expect_eq({tag, " load valid"}, 64'(hs.out_valid), 64'd0);
    expect_eq({tag, " header_len"}, 64'(header_len), 64'(len));
    for (int k = 0; k < nw; k++) begin
      @(negedge clk);
      if (k == stall_k) begin
        hs.out_ready = 1'b0;
        sv_fcsf = fcsf; sv_fcs = fcs;
        for (int s = 0; s < 3; s++) begin
          if (s == 0) begin
            start = 1'b1; fcsf = 2'd1; fcs = 64'hFF;
          end else begin
            start = 1'b0;
          end
          @(negedge clk);
          expect_eq({tag, " stall data"}, 64'(hs.out_data), 64'(ew[k]));
          expect_eq({tag, " stall valid"}, 64'(hs.out_valid), 64'd1);
          expect_eq({tag, " stall cfg_error"}, 64'(cfg_error), 64'd0);
        end
        start = 1'b0; fcsf = sv_fcsf; fcs = sv_fcs;
        hs.out_ready = 1'b1;
      end
      expect_eq({tag, $sformatf(" w%0d valid", k)}, 64'(hs.out_valid), 64'd1);
      expect_eq({tag, $sformatf(" w%0d data", k)}, 64'(hs.out_data), 64'(ew[k]));
      expect_eq({tag, $sformatf(" w%0d last", k)}, 64'(hs.out_last), (k == nw - 1) ? 64'd1 : 64'd0);
      if (k == nw - 1)
        expect_eq({tag, " last bytes"}, 64'(hs.out_bytes), 64'(last_bytes));
    end
    @(negedge clk);
    expect_eq({tag, " done"}, 64'(done), 64'd1);
    expect_eq({tag, " done busy"}, 64'(busy), 64'd0);
    expect_eq({tag, " done valid"}, 64'(hs.out_valid), 64'd0);
    @(negedge clk);
    expect_eq({tag, " done pulse"}, 64'(done), 64'd0);
    expect_eq({tag, " idle valid"}, 64'(hs.out_valid), 64'd0);
    @(negedge clk);
    expect_eq({tag, " idle busy"}, 64'(busy), 64'd0);
    expect_eq({tag, " idle valid2"}, 64'(hs.out_valid), 64'd0);
  endtask

  task automatic expect_cfg_error(input string tag);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    expect_eq({tag, " cfg_error"}, 64'(cfg_error), 64'd1);
    expect_eq({tag, " busy"}, 64'(busy), 64'd0);
    expect_eq({tag, " valid"}, 64'(hs.out_valid), 64'd0);
    @(negedge clk);
    expect_eq({tag, " cfg_error pulse"}, 64'(cfg_error), 64'd0);
    expect_eq({tag, " valid2"}, 64'(hs.out_valid), 64'd0);
    expect_eq({tag, " busy2"}, 64'(busy), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hs.out_ready = 1'b1;
    set_fields(1'b0, 1'b0, 2'd0, 2'd0, 8'h00, 32'h0, 64'h0);
    repeat (2) @(negedge clk);
    expect_eq("rst valid", 64'(hs.out_valid), 64'd0);
    expect_eq("rst last", 64'(hs.out_last), 64'd0);
    expect_eq("rst bytes", 64'(hs.out_bytes), 64'd0);
    expect_eq("rst data", 64'(hs.out_data), 64'd0);
    expect_eq("rst len", 64'(header_len), 64'd0);
    expect_eq("rst busy", 64'(busy), 64'd0);
    expect_eq("rst done", 64'(done), 64'd0);
    expect_eq("rst cfg_error", 64'(cfg_error), 64'd0);
    reset = 1'b0;

    // Case 1: single segment, 1-byte FCS; high FCS bits ignored.
    set_fields(1'b1, 1'b0, 2'd0, 2'd0, 8'h00, 32'h0, 64'hDEAD00000000002A);
    ew = '{16'hB528, 16'hFD2F, 16'h2A20, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    run_header("c1", 3, 5'd6, 2'd2, -1);

    // Case 2: WD, checksum, 2-byte DID, 2-byte FCS (value-256).
    set_fields(1'b0, 1'b1, 2'd2, 2'd1, 8'h58, 32'h1234, 64'h1000);
    ew = '{16'hB528, 16'hFD2F, 16'h5846, 16'h1234, 16'h0F00, 16'h0, 16'h0, 16'h0, 16'h0};
    run_header("c2", 5, 5'd10, 2'd2, -1);

    // Case 3: odd length, 1-byte DID; high DID bits ignored.
    set_fields(1'b0, 1'b0, 2'd1, 2'd0, 8'h50, 32'h123456AB, 64'h0);
    ew = '{16'hB528, 16'hFD2F, 16'h5001, 16'h00AB, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    run_header("c3", 4, 5'd7, 2'd1, -1);

    // Case 4: maximum 18-byte header.
    set_fields(1'b0, 1'b0, 2'd3, 2'd3, 8'h7A, 32'hDDCCBBAA, 64'h0807060504030201);
    ew = '{16'hB528, 16'hFD2F, 16'h7AC3, 16'hBBAA, 16'hDDCC,
           16'h0201, 16'h0403, 16'h0605, 16'h0807};
    run_header("c4", 9, 5'd18, 2'd2, -1);

    // Case 5: case 2 with back-pressure at word 2 and an ignored start.
    set_fields(1'b0, 1'b1, 2'd2, 2'd1, 8'h58, 32'h1234, 64'h1000);
    ew = '{16'hB528, 16'hFD2F, 16'h5846, 16'h1234, 16'h0F00, 16'h0, 16'h0, 16'h0, 16'h0};
    run_header("c5", 5, 5'd10, 2'd2, 2);

    // FCS range boundaries for the 2-byte field.
    set_fields(1'b0, 1'b0, 2'd0, 2'd1, 8'h00, 32'h0, 64'hFF);
    expect_cfg_error("e_ff");
    set_fields(1'b0, 1'b0, 2'd0, 2'd1, 8'h00, 32'h0, 64'h10100);
    expect_cfg_error("e_10100");
    set_fields(1'b1, 1'b0, 2'd0, 2'd1, 8'h00, 32'h0, 64'h100FF);
    ew = '{16'hB528, 16'hFD2F, 16'hFF60, 16'h00FF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    run_header("b_100ff", 4, 5'd7, 2'd1, -1);
    set_fields(1'b1, 1'b0, 2'd0, 2'd1, 8'h00, 32'h0, 64'h100);
    ew = '{16'hB528, 16'hFD2F, 16'h0060, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    run_header("b_100", 4, 5'd7, 2'd1, -1);

    // Reset during word 3 of case 4, then a fresh full header.
    set_fields(1'b0, 1'b0, 2'd3, 2'd3, 8'h7A, 32'hDDCCBBAA, 64'h0807060504030201);
    ew = '{16'hB528, 16'hFD2F, 16'h7AC3, 16'hBBAA, 16'hDDCC,
           16'h0201, 16'h0403, 16'h0605, 16'h0807};
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (3) @(negedge clk);
    expect_eq("rs word3 data", 64'(hs.out_data), 64'h7AC3);
    reset = 1'b1;
    @(negedge clk);
    expect_eq("rs valid", 64'(hs.out_valid), 64'd0);
    expect_eq("rs busy", 64'(busy), 64'd0);
    expect_eq("rs len", 64'(header_len), 64'd0);
    reset = 1'b0;
    run_header("rs c4", 9, 5'd18, 2'd2, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
